// File: rtl/load_ctrl_pkg.sv
// load_ctrl_pkg: shared FSM state type, funct3 codes and load pre-check helpers
package load_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} t_load_state;
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   function automatic logic f_load_legal(input logic [2:0] func_3);
      return func_3 inside {LB, LH, LW, LBU, LHU};
   endfunction
   function automatic logic f_load_misaligned(input logic [2:0] func_3, input logic [1:0] offset);
      return ((func_3 == LH || func_3 == LHU) && offset[0]) || (func_3 == LW && offset != 2'b00);
   endfunction
endpackage

// File: rtl/load_ctrl_if.sv
// load_ctrl_if: core request/response and data-memory port signals of load_ctrl
//   slave  : the controller side
//   master : the core + memory environment side
interface load_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [2:0]            req_func_3;
   logic                  kill;
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rsp_valid;
   logic [DATA_WIDTH-1:0] mem_rsp_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  load_addr_ma;
   logic                  illegal_instr;
   logic                  access_fault;
   logic                  busy;
   modport slave (
      input  req_valid, req_addr, req_func_3, kill, mem_req_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
      output req_ready, mem_req_valid, mem_addr, rsp_valid, rsp_data, load_addr_ma, illegal_instr,
             access_fault, busy
   );
   modport master (
      output req_valid, req_addr, req_func_3, kill, mem_req_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
      input  req_ready, mem_req_valid, mem_addr, rsp_valid, rsp_data, load_addr_ma, illegal_instr,
             access_fault, busy
   );
endinterface

// File: rtl/load_ctrl_mux.sv
// load_mux: extracts and sign/zero-extends the addressed byte/half/word of a memory word
//   i_func_3, i_offset, i_data -> o_data, o_load_addr_ma, o_illegal_instr
module load_mux
   import load_ctrl_pkg::*;
(
   input  logic [2:0]  i_func_3,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_data,
   output logic [31:0] o_data,
   output logic        o_load_addr_ma,
   output logic        o_illegal_instr
);
   logic [31:0] sh;
   always_comb begin
      sh              = i_data >> {i_offset, 3'b000};
      o_illegal_instr = !f_load_legal(i_func_3);
      o_load_addr_ma  = !o_illegal_instr && f_load_misaligned(i_func_3, i_offset);
      o_data          = i_func_3 == LB  ? {{24{sh[7]}}, sh[7:0]}   :
                        i_func_3 == LH  ? {{16{sh[15]}}, sh[15:0]} :
                        i_func_3 == LW  ? sh                       :
                        i_func_3 == LBU ? {24'd0, sh[7:0]}         :
                        i_func_3 == LHU ? {16'd0, sh[15:0]}        : '0;
   end
endmodule

// File: rtl/load_ctrl.sv
// load_ctrl: single-outstanding data-memory load sequencer with pre-check, watchdog and kill
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   bus (slave)     : core request/response, kill, and data-memory request/response
module load_ctrl
   import load_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic        i_clk,
   input logic        i_arst_n,
   load_ctrl_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
   t_load_state           state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            func_3_q, func_3_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  ma_q, ma_d, ill_q, ill_d, af_q, af_d;
   logic [CW-1:0]         wd_q, wd_d;
   logic [31:0]           mux_data;
   logic [1:0]            unused_mux_flags;
   load_mux u_load_mux (
      .i_func_3        (func_3_q),
      .i_offset        (addr_q[1:0]),
      .i_data          (bus.mem_rsp_data),
      .o_data          (mux_data),
      .o_load_addr_ma  (unused_mux_flags[0]),
      .o_illegal_instr (unused_mux_flags[1])
   );
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      func_3_d = func_3_q;
      data_d   = data_q;
      ma_d     = ma_q;
      ill_d    = ill_q;
      af_d     = af_q;
      wd_d     = wd_q;
      unique case (state_q)
         IDLE: if (bus.req_valid && !bus.kill) begin
            addr_d   = bus.req_addr;
            func_3_d = bus.req_func_3;
            ill_d    = !f_load_legal(bus.req_func_3);
            ma_d     = !ill_d && f_load_misaligned(bus.req_func_3, bus.req_addr[1:0]);
            data_d   = '0;
            state_d  = (ill_d || ma_d) ? RESP : REQ;
         end
         REQ: if (bus.kill) state_d = IDLE;
         else if (bus.mem_req_ready) begin
            state_d = WAIT;
            wd_d    = '0;
         end
         // kill wins over data and timeout; a coincident response is simply dropped
         WAIT: if (bus.kill) state_d = bus.mem_rsp_valid ? IDLE : DRAIN;
         else if (bus.mem_rsp_valid) begin
            data_d  = mux_data;
            state_d = RESP;
         end else if (wd_q == WD_LAST) begin
            af_d    = 1'b1;
            data_d  = '0;
            state_d = RESP;
         end else wd_d = wd_q + 1'b1;
         // the watchdog keeps its WAIT count so WAIT+DRAIN together stay bounded
         DRAIN: if (bus.mem_rsp_valid || wd_q == WD_LAST) state_d = IDLE;
         else wd_d = wd_q + 1'b1;
         RESP: if (bus.rsp_ready || bus.kill) begin
            state_d = IDLE;
            data_d  = '0;
            ma_d    = 1'b0;
            ill_d   = 1'b0;
            af_d    = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         func_3_q <= '0;
         data_q   <= '0;
         ma_q     <= 1'b0;
         ill_q    <= 1'b0;
         af_q     <= 1'b0;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         func_3_q <= func_3_d;
         data_q   <= data_d;
         ma_q     <= ma_d;
         ill_q    <= ill_d;
         af_q     <= af_d;
         wd_q     <= wd_d;
      end
   end
   assign bus.req_ready     = state_q == IDLE && !bus.kill;
   assign bus.mem_req_valid = state_q == REQ;
   assign bus.mem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign bus.rsp_valid     = state_q == RESP;
   assign bus.rsp_data      = data_q;
   assign bus.load_addr_ma  = ma_q;
   assign bus.illegal_instr = ill_q;
   assign bus.access_fault  = af_q;
   assign bus.busy          = state_q != IDLE;
endmodule
